dec_window_accumulator: RTL

- Stage directly downstream of the decimation clock divider.
- Consumes the divider's `dec_clk` in the system `clk` domain and integrates input samples over each decimation window (integrate-and-dump).
- Pushes one {sum, count} result per window into a small output FIFO with a valid/ready handshake.
- Forms the first decimation stage feeding downstream filtering/packing logic.

---
 rtl/dec_window_accumulator_if.sv | 29 ++
 rtl/dec_window_accumulator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dec_window_accumulator_if.sv
// Sample/result bus for the decimation window accumulator.
// The bench side drives the sample and control inputs; the design consumes them and returns results.
interface dec_window_accumulator_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 8
);
  logic              en;
  logic              dec_clk;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              flag_clr;
  logic [ACC_W-1:0]  dout;
  logic [CNT_W-1:0]  dout_cnt;
  logic              dout_valid;
  logic              dout_ready;
  logic              overflow;
  logic              sat;

  modport master (
    output en, dec_clk, din, din_valid, flag_clr, dout_ready,
    input  dout, dout_cnt, dout_valid, overflow, sat
  );

  modport slave (
    input  en, dec_clk, din, din_valid, flag_clr, dout_ready,
    output dout, dout_cnt, dout_valid, overflow, sat
  );
endinterface

// File: rtl/dec_window_accumulator.sv
// Integrate-and-dump over each dec_clk window with a saturating accumulator.
// Each {sum, count} result is queued in a small FIFO with a valid/ready handshake.
module dec_window_accumulator #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  dec_window_accumulator_if.slave bus_io
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   PtrOne = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  state_e             state_q;
  logic               dec_q;
  logic               edge_w;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   din_ext;
  logic [ACC_W:0]     sum_w;
  logic [ACC_W-1:0]   add_res;
  logic               add_ovf;
  logic [ACC_W-1:0]   start_acc;
  logic [CNT_W-1:0]   start_cnt;
  logic               accumulate;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               drop;
  logic [PTR_W:0]     wr_ptr_q;
  logic [PTR_W:0]     rd_ptr_q;
  logic [ACC_W-1:0]   mem_sum_q [DEPTH];
  logic [CNT_W-1:0]   mem_cnt_q [DEPTH];
  logic               overflow_q;
  logic               sat_q;

  assign edge_w  = bus_io.dec_clk & ~dec_q;
  assign din_ext = ACC_W'($signed(bus_io.din));

  // One extra bit catches signed overflow; clamp toward the rail of the true sign.
  always_comb begin
    sum_w   = {acc_q[ACC_W-1], acc_q} + {din_ext[ACC_W-1], din_ext};
    add_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    add_res = sum_w[ACC_W-1:0];
    if (add_ovf) begin
      add_res = sum_w[ACC_W] ? AccMin : AccMax;
    end
  end

  always_comb begin
    start_acc  = bus_io.din_valid ? din_ext : '0;
    start_cnt  = bus_io.din_valid ? CNT_W'(1) : '0;
    accumulate = (state_q == StRun) && bus_io.en && !edge_w && bus_io.din_valid;
    push       = (state_q == StRun) && bus_io.en && edge_w && (cnt_q != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= bus_io.dec_clk;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (!bus_io.en) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StArm;
        end
        StArm: begin
          if (edge_w) begin
            state_q <= StRun;
            acc_q   <= start_acc;
            cnt_q   <= start_cnt;
          end
        end
        StRun: begin
          if (edge_w) begin
            acc_q <= start_acc;
            cnt_q <= start_cnt;
          end else if (bus_io.din_valid) begin
            acc_q <= add_res;
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop   = !empty && bus_io.dout_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_sum_q[wr_ptr_q[PTR_W-1:0]] <= acc_q;
      mem_cnt_q[wr_ptr_q[PTR_W-1:0]] <= cnt_q;
    end
  end

  // A set event in the same cycle as flag_clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      overflow_q <= (overflow_q && !bus_io.flag_clr) || drop;
      sat_q      <= (sat_q && !bus_io.flag_clr) || (accumulate && add_ovf);
    end
  end

  assign bus_io.dout_valid = !empty;
  assign bus_io.dout       = empty ? '0 : mem_sum_q[rd_ptr_q[PTR_W-1:0]];
  assign bus_io.dout_cnt   = empty ? '0 : mem_cnt_q[rd_ptr_q[PTR_W-1:0]];
  assign bus_io.overflow   = overflow_q;
  assign bus_io.sat        = sat_q;

endmodule
